// File: rtl/serial_parity_frame.sv
// serial_parity_frame: framed serial parity checker (DATA_BITS data + 1 parity).
// In: clk, rst_n, x, x_valid, sync, odd_mode. Out: z, expected_p, frame_done,
// parity_err, err_count (saturating), in_parity.
module serial_parity_frame #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             sync,
  input  logic             odd_mode,
  output logic             z,
  output logic             expected_p,
  output logic             frame_done,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count,
  output logic             in_parity
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [0:0] S_DATA = 1'b0;
  localparam logic [0:0] S_PAR  = 1'b1;

  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic [0:0]       r_state;
  logic [BW-1:0]    r_bcnt;
  logic             r_z;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_err;
  logic             w_sat;

  assign w_err = r_z ^ x ^ odd_mode;
  assign w_sat = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_DATA;
      r_bcnt  <= '0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // sync wins over a bit presented on the same edge
      if (sync) begin
        r_state <= S_DATA;
        r_bcnt  <= '0;
        r_z     <= 1'b0;
      end else if (x_valid) begin
        unique case (1'b1)
          (r_state == S_DATA): begin
            r_z <= r_z ^ x;
            if (r_bcnt == LAST) begin
              r_bcnt  <= '0;
              r_state <= S_PAR;
            end else begin
              r_bcnt <= r_bcnt + BW'(1);
            end
          end
          (r_state == S_PAR): begin
            r_done <= 1'b1;
            r_err  <= w_err;
            if (w_err && !w_sat) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            r_z     <= 1'b0;
            r_state <= S_DATA;
          end
          default: begin
            r_state <= S_DATA;
          end
        endcase
      end
    end
  end

  assign z          = r_z;
  assign expected_p = r_z ^ odd_mode;
  assign frame_done = r_done;
  assign parity_err = r_err;
  assign err_count  = r_cnt;
  assign in_parity  = (r_state == S_PAR);

endmodule

// File: tb/tb_serial_parity_frame.sv
// tb_serial_parity_frame: table vectors, corner sequences and random stream
// checked against a frame-level reference model for three configurations.
module tb_serial_parity_frame;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic x_valid = 1'b0;
  logic sync = 1'b0;
  logic odd_mode = 1'b0;

  logic       m_zo, m_ep, m_fd, m_pe, m_ip;
  logic [7:0] m_ec;
  logic       s_zo, s_ep, s_fd, s_pe, s_ip;
  logic [1:0] s_ec;
  logic       o_zo, o_ep, o_fd, o_pe, o_ip;
  logic [7:0] o_ec;

  always #5 clk = ~clk;

  serial_parity_frame #(.DATA_BITS(8), .CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sync(sync),
    .odd_mode(odd_mode), .z(m_zo), .expected_p(m_ep), .frame_done(m_fd),
    .parity_err(m_pe), .err_count(m_ec), .in_parity(m_ip));

  serial_parity_frame #(.DATA_BITS(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sync(sync),
    .odd_mode(odd_mode), .z(s_zo), .expected_p(s_ep), .frame_done(s_fd),
    .parity_err(s_pe), .err_count(s_ec), .in_parity(s_ip));

  serial_parity_frame #(.DATA_BITS(1), .CNT_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .sync(sync),
    .odd_mode(odd_mode), .z(o_zo), .expected_p(o_ep), .frame_done(o_fd),
    .parity_err(o_pe), .err_count(o_ec), .in_parity(o_ip));

  int tests = 0;
  int fails = 0;

  // reference model: bits accepted in current frame, running parity, counts
  int mn, on_;
  logic mz, oz;
  logic md, me, od, oe;
  int mcnt, scnt, ocnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mn = 0; on_ = 0; mz = 0; oz = 0;
    md = 0; me = 0; od = 0; oe = 0;
    mcnt = 0; scnt = 0; ocnt = 0;
  endtask

  task automatic model_edge(input logic bx, input logic bv,
                            input logic bs, input logic bo);
    logic e;
    md = 0; me = 0; od = 0; oe = 0;
    if (bs) begin
      mn = 0; mz = 0; on_ = 0; oz = 0;
    end else if (bv) begin
      if (mn < 8) begin
        mz = mz ^ bx; mn++;
      end else begin
        e = mz ^ bx ^ bo;
        md = 1; me = e;
        if (e && mcnt < 255) mcnt++;
        if (e && scnt < 3) scnt++;
        mn = 0; mz = 0;
      end
      if (on_ < 1) begin
        oz = oz ^ bx; on_++;
      end else begin
        e = oz ^ bx ^ bo;
        od = 1; oe = e;
        if (e && ocnt < 255) ocnt++;
        on_ = 0; oz = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("main_z", m_zo, mz);
    chk("main_in_parity", m_ip, (mn == 8));
    chk("main_expected_p", m_ep, mz ^ odd_mode);
    chk("main_frame_done", m_fd, md);
    chk("main_parity_err", m_pe, me);
    chk("main_err_count", m_ec, mcnt);
    chk("sat_frame_done", s_fd, md);
    chk("sat_parity_err", s_pe, me);
    chk("sat_err_count", s_ec, scnt);
    chk("one_z", o_zo, oz);
    chk("one_in_parity", o_ip, (on_ == 1));
    chk("one_expected_p", o_ep, oz ^ odd_mode);
    chk("one_frame_done", o_fd, od);
    chk("one_parity_err", o_pe, oe);
    chk("one_err_count", o_ec, ocnt);
  endtask

  task automatic step(input logic bx, input logic bv,
                      input logic bs, input logic bo);
    x = bx; x_valid = bv; sync = bs; odd_mode = bo;
    @(posedge clk);
    model_edge(bx, bv, bs, bo);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    x_valid = 0; sync = 0; x = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       odd;
    logic       exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[7];
  int   sat_exp[5];
  int   done_idx[$];

  initial begin
    tbl[0] = '{8'b1011_0010, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{8'b1011_0010, 1'b1, 1'b0, 1'b1, 1};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 2};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b0, 2};
    tbl[6] = '{8'h07, 1'b1, 1'b1, 1'b1, 3};
    sat_exp = '{1, 2, 3, 3, 3};

    model_reset();
    #2;
    odd_mode = 1;
    #1;
    chk("rst_expected_p_odd", m_ep, 1);
    odd_mode = 0;
    #1;
    chk("rst_expected_p_even", m_ep, 0);
    do_reset();

    // table-driven frames
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(tbl[r].data[i], 1, 0, tbl[r].odd);
        if (tbl[r].odd && tbl[r].data == 8'h00)
          chk("odd_expected_p", m_ep, 1);
      end
      step(tbl[r].par, 1, 0, tbl[r].odd);
      chk("tbl_done", m_fd, 1);
      chk("tbl_err", m_pe, tbl[r].exp_err);
      chk("tbl_cnt", m_ec, tbl[r].exp_cnt);
    end
    step(0, 0, 0, 0);
    chk("pulse_drop", m_fd, 0);

    // three back-to-back frames
    do_reset();
    for (int k = 0; k < 27; k++) begin
      step(1'($urandom_range(0, 1)), 1, 0, 0);
      if (m_fd) done_idx.push_back(k);
    end
    chk("b2b_count", done_idx.size(), 3);
    if (done_idx.size() == 3) begin
      chk("b2b_idx0", done_idx[0], 8);
      chk("b2b_idx1", done_idx[1], 17);
      chk("b2b_idx2", done_idx[2], 26);
    end

    // sync mid-frame after one bad frame
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("sync_pre_cnt", m_ec, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("sync_z", m_zo, 0);
    chk("sync_in_parity", m_ip, 0);
    chk("sync_cnt_hold", m_ec, 1);
    for (int i = 0; i < 8; i++) step(i[0], 1, 0, 0);
    step(0, 1, 0, 0);
    chk("sync_frame_done", m_fd, 1);
    chk("sync_frame_err", m_pe, 0);
    chk("sync_frame_cnt", m_ec, 1);

    // sync on a parity bit: no pulse
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("sync_par_no_done", m_fd, 0);

    // saturation with 2-bit counter
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      chk("sat_pulse", s_pe, 1);
      chk("sat_count", s_ec, sat_exp[f]);
    end

    // reset mid-frame
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    x = 0; x_valid = 1; odd_mode = 0;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    chk("rst_hold_done", m_fd, 0);
    chk("rst_hold_z", m_zo, 0);
    @(negedge clk);
    rst_n = 1;
    x_valid = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("post_rst_frame", m_fd, 1);

    // DATA_BITS=1 pairs
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("one_pair0_done", o_fd, 1);
    chk("one_pair0_err", o_pe, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("one_pair1_err", o_pe, 1);
    chk("one_pair1_cnt", o_ec, 1);

    // random gapped stream with occasional sync
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
